// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: the fetch FSM encoding, the NOP word
// that decode sees while no instruction has been fetched, and the default datapath width.
package riscv_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        TRAP
    } fetch_state_e;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port: a valid/ready request carrying the fetch address,
// followed by a valid-only response carrying the instruction word.
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;

    modport master (
        output req_valid, addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pc_next_select.sv
// Next-PC mux and word-alignment check. The block has no adder because the
// PC+4 value is produced outside it.
module pc_next_select #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] branch_target,
    input  logic            branch_taken,
    output logic [XLEN-1:0] next_pc,
    output logic            next_misaligned
);
    assign next_pc         = branch_taken ? branch_target : pc_plus4;
    assign next_misaligned = |next_pc[1:0];
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the architectural PC, fetches one instruction per
// REQ/WAIT/HOLD round trip, and drops into a sticky trap on a misaligned next PC.
module pc_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [XLEN-1:0]       branch_target,
    input  logic                  branch_taken,
    input  logic                  stall,
    pc_fetch_unit_if.master       imem,
    output logic [XLEN-1:0]       pc,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic                  misaligned
);
    import riscv_pkg::*;

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            pc_load;
    logic            instr_load;

    pc_next_select #(.XLEN(XLEN)) u_next (
        .pc_plus4        (pc_plus4),
        .branch_target   (branch_target),
        .branch_taken    (branch_taken),
        .next_pc         (next_pc),
        .next_misaligned (next_misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            state <= state_next;
            if (pc_load)    pc    <= next_pc;
            if (instr_load) instr <= imem.rsp_data;
        end
    end

    // The memory response is sampled only in WAIT, so a response that arrives
    // around a reset or while stalled cannot overwrite instr.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        case (state)
            BOOT: state_next = REQ;
            REQ:  if (imem.req_ready) state_next = WAIT;
            WAIT: if (imem.rsp_valid) begin
                instr_load = 1'b1;
                state_next = HOLD;
            end
            HOLD: if (!stall) begin
                if (next_misaligned) begin
                    state_next = TRAP;
                end else begin
                    pc_load    = 1'b1;
                    state_next = REQ;
                end
            end
            TRAP:    state_next = TRAP;
            default: state_next = BOOT;
        endcase
    end

    assign imem.req_valid = (state == REQ);
    assign imem.addr      = pc;
    assign instr_valid    = (state == HOLD);
    assign misaligned     = (state == TRAP);
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural program counter and fetches the instruction at PC from instruction memory over a valid/ready request and valid response handshake.
- Consumes the PC+4 value produced by the PC adder and the branch/jump target from the execute stage.
- Selects and registers the next PC, presents the fetched instruction to decode, and traps on misaligned targets.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_plus4  in  XLEN  PC+4 from the PC adder.
- branch_target  in  XLEN  branch/jump target address.
- branch_taken  in  1  select branch_target instead of pc_plus4 on advance.
- stall  in  1  hold the current instruction; no advance.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_rsp_valid  in  1  instruction word valid.
- imem_rsp_data  in  32  fetched instruction word.
- pc  out  XLEN  current program counter, fed to the PC adder.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  instr corresponds to pc and is ready for decode.
- misaligned  out  1  sticky trap flag: next-PC bits [1:0] were nonzero.

Behaviour:
- Reset:
  - pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req_valid=0, misaligned=0, state=BOOT.
  - Reset applies in any state. Any in-flight memory response is discarded because rsp is sampled only in WAIT.
- States: BOOT, REQ, WAIT, HOLD, TRAP.
- BOOT: lasts one cycle, then REQ. No outputs asserted.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - imem_addr stays stable until imem_req_ready=1.
  - On handshake (valid&ready), go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: instr<=imem_rsp_data, go to HOLD. instr_valid rises the following cycle.
  - rsp_valid in any state other than WAIT is ignored.
- HOLD:
  - instr_valid=1.
  - stall=1: remain; pc and instr unchanged. branch_taken is ignored while stalled; upstream must hold it.
  - stall=0: next = branch_taken ? branch_target : pc_plus4.
    - next[1:0]==0: pc<=next, instr_valid<=0, go to REQ.
    - next[1:0]!=0: pc unchanged, instr_valid<=0, misaligned<=1, go to TRAP.
- TRAP: absorbing until reset. All request outputs 0; misaligned held at 1.
- Latency: with a zero-wait memory (ready=1, response the cycle after the request), one instruction completes every 3 cycles (REQ, WAIT, HOLD).
- Arithmetic: no adder inside this block; PC+4 is external. Wrap-around is accepted: pc_plus4=0 from pc=32'hFFFF_FFFC is aligned and is fetched.
- pc changes only on the HOLD->REQ transition or reset.
- imem_addr is pc combinationally; it is only meaningful when imem_req_valid=1.

Decomposition:
- Shared package (riscv_pkg) holds:
  - fetch state encoding enum (BOOT/REQ/WAIT/HOLD/TRAP);
  - NOP_INSTR=32'h0000_0013;
  - XLEN default.
- One natural sub-module: pc_next_select. It is the combinational next-PC mux plus alignment check (outputs next_pc, next_misaligned). The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset, then zero-wait memory returning 32'h00500093 at addr 0 -> imem_addr=0 in REQ; instr=32'h00500093 with instr_valid=1 in cycle 3; pc advances to pc_plus4=4; next request at addr 4.
- imem_req_ready held low for 5 cycles in REQ -> imem_req_valid=1 and imem_addr=0 stable all 5 cycles; WAIT entered only after ready=1.
- In HOLD, stall=1 for 4 cycles with branch_taken=1, branch_target=0x40, then stall=0 with branch_taken=1 -> pc stays at old value during stall; then pc=0x40 and next fetch at 0x40.
- Advance with branch_taken=1, branch_target=0x0000_0042 -> misaligned=1, pc unchanged, no further imem_req_valid; reset clears misaligned and restarts at RESET_PC.
- pc=32'hFFFF_FFFC, pc_plus4=0, stall=0 -> pc wraps to 0, misaligned stays 0, fetch at 0.
- Reset asserted in WAIT with imem_rsp_valid=1 the same and next cycle -> instr stays NOP, instr_valid=0; FSM goes BOOT->REQ and fetches RESET_PC.
